// File: rtl/adder_pipe_pkg.sv
// Shared constants and types for the pipelined add/subtract unit.
// The optional ADDER_PIPE_SAT_EN macro only affects adder_pipe.sv.
package adder_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Control half of a stage record; the width-dependent data half lives in adder_pipe.
  typedef struct packed {
    logic valid;
    logic carry;
    logic msb_carry_in;
    logic ovf;
    logic zero;
  } stage_flags_t;

  function automatic int unsigned stages_of(input int unsigned width,
                                            input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit full adder slice: sum, carry out, and carry into its top bit.
module adder_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
  assign s     = full[W-1:0];
  assign co    = full[W];
  // Carry into the top bit is recovered from the top-bit sum equation.
  assign c_msb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one CHUNK slice resolved per stage, valid/ready on both sides.
// Define ADDER_PIPE_SAT_EN to saturate signed overflow in the last stage.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             v,
  output logic             z
);

  localparam int unsigned STAGES = stages_of(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("adder_pipe: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] yy;
    stage_flags_t     flags;
  } stage_t;

  stage_t stage_q [STAGES];
  logic   advance;

  // The whole pipe moves together; bubbles are held too so outputs stay stable.
  assign advance  = !stage_q[STAGES-1].flags.valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;

    stage_t           st_in;
    stage_t           st_out;
    stage_t           q;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic             chunk_msb;

    if (k == 0) begin : g_head
      always_comb begin
        st_in             = '0;
        st_in.x           = x;
        st_in.yy          = (sub == MODE_ADD) ? y : ~y;
        st_in.flags.valid = in_valid;
        st_in.flags.carry = ci ^ (sub == MODE_SUB);
      end
    end else begin : g_body
      assign st_in = stage_q[k-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a     (st_in.x[LO +: CHUNK]),
      .b     (st_in.yy[LO +: CHUNK]),
      .ci    (st_in.flags.carry),
      .s     (chunk_s),
      .co    (chunk_co),
      .c_msb (chunk_msb)
    );

    // Resolve this slice; the last stage also produces the final flags.
    always_comb begin
      st_out                    = st_in;
      st_out.sum[LO +: CHUNK]   = chunk_s;
      st_out.flags.carry        = chunk_co;
      st_out.flags.msb_carry_in = chunk_msb;
      if (k == STAGES - 1) begin
        st_out.flags.ovf = chunk_co ^ chunk_msb;
`ifdef ADDER_PIPE_SAT_EN
        if (st_out.flags.ovf) begin
          st_out.sum = st_in.x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        st_out.flags.zero = (st_out.sum == '0);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (advance) begin
        q <= st_out;
      end
    end

    assign stage_q[k] = q;
  end

  assign out_valid = stage_q[STAGES-1].flags.valid;
  assign s         = stage_q[STAGES-1].sum;
  assign co        = stage_q[STAGES-1].flags.carry;
  assign v         = stage_q[STAGES-1].flags.ovf;
  assign z         = stage_q[STAGES-1].flags.zero;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe at WIDTH=16, CHUNK=4 (four stages).
module tb_adder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        co;
  logic        v;
  logic        z;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [15:0] OVF_ADD_S = 16'h7FFF;
  localparam logic [15:0] OVF_SUB_S = 16'h8000;
`else
  localparam logic [15:0] OVF_ADD_S = 16'h8000;
  localparam logic [15:0] OVF_SUB_S = 16'h7FFF;
`endif

  adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .v         (v),
    .z         (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one op, then report the result and how many rising edges (accept edge = 1) it took.
  task automatic run_single(input logic [15:0] ax, input logic [15:0] ay,
                            input logic aci, input logic asub,
                            output logic [15:0] rs, output logic rco,
                            output logic rv, output logic rz, output int lat);
    @(negedge clk);
    x = ax; y = ay; ci = aci; sub = asub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 20) lat = 99;
    rs = s; rco = co; rv = v; rz = z;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; ci = 1'b0; sub = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (s !== 16'h0000) $display("FAIL reset_s: got %h want 0000", s); else n_pass++;
    n_checks++; if (co !== 1'b0) $display("FAIL reset_co: got %b want 0", co); else n_pass++;
    n_checks++; if (v !== 1'b0) $display("FAIL reset_v: got %b want 0", v); else n_pass++;
    n_checks++; if (z !== 1'b0) $display("FAIL reset_z: got %b want 0", z); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_add();
    logic [15:0] rs;
    logic        rco, rv, rz;
    int          lat;
    run_single(16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rco, rv, rz, lat);
    n_checks++; if (lat != 4) $display("FAIL add_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (rs !== 16'h0100) $display("FAIL add1_s: got %h want 0100", rs); else n_pass++;
    n_checks++; if (rco !== 1'b0) $display("FAIL add1_co: got %b want 0", rco); else n_pass++;
    n_checks++; if (rv !== 1'b0) $display("FAIL add1_v: got %b want 0", rv); else n_pass++;
    n_checks++; if (rz !== 1'b0) $display("FAIL add1_z: got %b want 0", rz); else n_pass++;
    run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rco, rv, rz, lat);
    n_checks++; if (rs !== 16'h0000) $display("FAIL add2_s: got %h want 0000", rs); else n_pass++;
    n_checks++; if (rco !== 1'b1) $display("FAIL add2_co: got %b want 1", rco); else n_pass++;
    n_checks++; if (rv !== 1'b0) $display("FAIL add2_v: got %b want 0", rv); else n_pass++;
    n_checks++; if (rz !== 1'b1) $display("FAIL add2_z: got %b want 1", rz); else n_pass++;
    run_single(16'h1234, 16'h4321, 1'b1, 1'b0, rs, rco, rv, rz, lat);
    n_checks++; if (rs !== 16'h5556) $display("FAIL add3_s: got %h want 5556", rs); else n_pass++;
    n_checks++; if (rco !== 1'b0) $display("FAIL add3_co: got %b want 0", rco); else n_pass++;
  endtask

  task automatic test_sub();
    logic [15:0] rs;
    logic        rco, rv, rz;
    int          lat;
    run_single(16'h0005, 16'h0005, 1'b0, 1'b1, rs, rco, rv, rz, lat);
    n_checks++; if (rs !== 16'h0000) $display("FAIL sub1_s: got %h want 0000", rs); else n_pass++;
    n_checks++; if (rco !== 1'b1) $display("FAIL sub1_co: got %b want 1", rco); else n_pass++;
    n_checks++; if (rz !== 1'b1) $display("FAIL sub1_z: got %b want 1", rz); else n_pass++;
    run_single(16'h0003, 16'h0005, 1'b0, 1'b1, rs, rco, rv, rz, lat);
    n_checks++; if (rs !== 16'hFFFE) $display("FAIL sub2_s: got %h want fffe", rs); else n_pass++;
    n_checks++; if (rco !== 1'b0) $display("FAIL sub2_co: got %b want 0", rco); else n_pass++;
    n_checks++; if (rv !== 1'b0) $display("FAIL sub2_v: got %b want 0", rv); else n_pass++;
    n_checks++; if (rz !== 1'b0) $display("FAIL sub2_z: got %b want 0", rz); else n_pass++;
    run_single(16'h0010, 16'h0001, 1'b1, 1'b1, rs, rco, rv, rz, lat);
    n_checks++; if (rs !== 16'h000E) $display("FAIL sub3_s: got %h want 000e", rs); else n_pass++;
    n_checks++; if (rco !== 1'b1) $display("FAIL sub3_co: got %b want 1", rco); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] rs;
    logic        rco, rv, rz;
    int          lat;
    run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rco, rv, rz, lat);
    n_checks++; if (rs !== OVF_ADD_S) $display("FAIL ovf_add_s: got %h want %h", rs, OVF_ADD_S); else n_pass++;
    n_checks++; if (rco !== 1'b0) $display("FAIL ovf_add_co: got %b want 0", rco); else n_pass++;
    n_checks++; if (rv !== 1'b1) $display("FAIL ovf_add_v: got %b want 1", rv); else n_pass++;
    n_checks++; if (rz !== 1'b0) $display("FAIL ovf_add_z: got %b want 0", rz); else n_pass++;
    run_single(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rco, rv, rz, lat);
    n_checks++; if (rs !== OVF_SUB_S) $display("FAIL ovf_sub_s: got %h want %h", rs, OVF_SUB_S); else n_pass++;
    n_checks++; if (rco !== 1'b1) $display("FAIL ovf_sub_co: got %b want 1", rco); else n_pass++;
    n_checks++; if (rv !== 1'b1) $display("FAIL ovf_sub_v: got %b want 1", rv); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] tx [8];
    logic [15:0] ty [8];
    logic [15:0] es [8];
    logic        tci [8];
    logic        tsub [8];
    logic        eco [8];
    logic        ev [8];
    logic        ez [8];
    logic [15:0] held;
    logic        stalled, acc, xfer;
    int          ix, rx, cyc;
    tx[0]=16'h1111; ty[0]=16'h2222; tci[0]=0; tsub[0]=0; es[0]=16'h3333; eco[0]=0; ev[0]=0; ez[0]=0;
    tx[1]=16'hFFFF; ty[1]=16'hFFFF; tci[1]=1; tsub[1]=0; es[1]=16'hFFFF; eco[1]=1; ev[1]=0; ez[1]=0;
    tx[2]=16'h1000; ty[2]=16'h0001; tci[2]=0; tsub[2]=1; es[2]=16'h0FFF; eco[2]=1; ev[2]=0; ez[2]=0;
    tx[3]=16'h0000; ty[3]=16'h0001; tci[3]=0; tsub[3]=1; es[3]=16'hFFFF; eco[3]=0; ev[3]=0; ez[3]=0;
    tx[4]=16'hABCD; ty[4]=16'h5433; tci[4]=0; tsub[4]=0; es[4]=16'h0000; eco[4]=1; ev[4]=0; ez[4]=1;
    tx[5]=16'h7000; ty[5]=16'h1234; tci[5]=1; tsub[5]=1; es[5]=16'h5DCB; eco[5]=1; ev[5]=0; ez[5]=0;
    tx[6]=16'h00F0; ty[6]=16'h0F0F; tci[6]=1; tsub[6]=0; es[6]=16'h1000; eco[6]=0; ev[6]=0; ez[6]=0;
    tx[7]=16'h8001; ty[7]=16'h0001; tci[7]=0; tsub[7]=1; es[7]=16'h8000; eco[7]=1; ev[7]=0; ez[7]=0;
    ix = 0; rx = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (rx < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (ix < 8) begin
        in_valid = 1'b1; x = tx[ix]; y = ty[ix]; ci = tci[ix]; sub = tsub[ix];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_checks++; if (in_ready !== !(out_valid && !out_ready)) $display("FAIL b2b_in_ready: got %b want %b (cycle %0d)", in_ready, !(out_valid && !out_ready), cyc); else n_pass++;
      if (stalled) begin
        n_checks++; if (s !== held || out_valid !== 1'b1) $display("FAIL b2b_hold: got s=%h valid=%b want s=%h valid=1", s, out_valid, held); else n_pass++;
      end
      xfer = out_valid && out_ready;
      if (xfer) begin
        n_checks++; if (s !== es[rx]) $display("FAIL b2b_s[%0d]: got %h want %h", rx, s, es[rx]); else n_pass++;
        n_checks++; if (co !== eco[rx]) $display("FAIL b2b_co[%0d]: got %b want %b", rx, co, eco[rx]); else n_pass++;
        n_checks++; if (v !== ev[rx]) $display("FAIL b2b_v[%0d]: got %b want %b", rx, v, ev[rx]); else n_pass++;
        n_checks++; if (z !== ez[rx]) $display("FAIL b2b_z[%0d]: got %b want %b", rx, z, ez[rx]); else n_pass++;
        rx++;
      end
      acc     = in_valid && in_ready;
      stalled = out_valid && !out_ready;
      held    = s;
      @(posedge clk);
      if (acc) ix++;
      cyc++;
    end
    #1 in_valid = 1'b0;
    n_checks++; if (rx != 8) $display("FAIL b2b_count: got %0d results want 8", rx); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] rs;
    logic        rco, rv, rz, seen;
    int          lat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = 16'(i + 1); y = 16'h0100; ci = 1'b0; sub = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_fill: got out_valid=%b want 1", out_valid); else n_pass++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (s !== 16'h0000) $display("FAIL mid_s: got %h want 0000", s); else n_pass++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL mid_no_ghost: got out_valid seen=%b want 0", seen); else n_pass++;
    run_single(16'h0ABC, 16'h0001, 1'b0, 1'b0, rs, rco, rv, rz, lat);
    n_checks++; if (lat != 4) $display("FAIL mid_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (rs !== 16'h0ABD) $display("FAIL mid_s_after: got %h want 0abd", rs); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
